dmem_lsu: RTL and testbench

//  Load/store initiator for the word-only data memory. Takes one request at a

---
 rtl/dmem_lsu.sv | 198 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for the word-only data memory.
// Takes one request at a time. Loads go through READ and stores through WRITE.
// Sub-word stores do a read-modify-write: READ, then WRITE.
// Optional macro MISALIGN_TRAP_EN: when defined, a misaligned halfword or word
// access faults with no memory access. When undefined, the low address bits
// are masked and the access proceeds.
module dmem_lsu #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_lane;
  logic [15:0] lat_wdata;

  logic        funct3_ok;
  logic        out_of_range;
  logic        misaligned;
  logic        req_err;
  logic        accept;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept = req_valid && req_ready;

  // Classify the incoming request: bad funct3, out-of-range address or trapped misalignment
  always_comb begin
    funct3_ok    = 1'b0;
    out_of_range = 1'b0;
    misaligned   = 1'b0;
    if (req_we) begin
      funct3_ok = (req_funct3 <= 3'b010);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
        default:                                funct3_ok = 1'b0;
      endcase
    end
    out_of_range = (req_addr >= ADDR_W'(MEM_BYTES));
`ifdef MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
      misaligned = 1'b1;
    end
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      misaligned = 1'b1;
    end
`endif
    req_err = !funct3_ok || out_of_range || misaligned;
  end

  // Pick the addressed lane from the read word and extend it for loads
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    load_data = 32'h0;
    case (lat_lane)
      2'd0:    byte_lane = mem_read_data[7:0];
      2'd1:    byte_lane = mem_read_data[15:8];
      2'd2:    byte_lane = mem_read_data[23:16];
      default: byte_lane = mem_read_data[31:24];
    endcase
    half_lane = lat_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_data = {24'h0, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_data = {16'h0, half_lane};
      default: load_data = mem_read_data;
    endcase
  end

  // Splice the store byte/half into the old word for read-modify-write
  always_comb begin
    merged_word = mem_read_data;
    if (lat_funct3[1:0] == 2'b00) begin
      case (lat_lane)
        2'd0:    merged_word[7:0]   = lat_wdata[7:0];
        2'd1:    merged_word[15:8]  = lat_wdata[7:0];
        2'd2:    merged_word[23:16] = lat_wdata[7:0];
        default: merged_word[31:24] = lat_wdata[7:0];
      endcase
    end else if (lat_funct3[1:0] == 2'b01) begin
      if (lat_lane[1]) begin
        merged_word[31:16] = lat_wdata;
      end else begin
        merged_word[15:0] = lat_wdata;
      end
    end
  end

  // Request FSM with registered outputs; async reset clears write enable at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      lat_we           <= 1'b0;
      lat_funct3       <= 3'b000;
      lat_lane         <= 2'b00;
      lat_wdata        <= 16'h0;
      req_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= 32'h0;
      rsp_err          <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid        <= 1'b0;
          rsp_rdata        <= 32'h0;
          rsp_err          <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
          mem_addr         <= '0;
          mem_write_data   <= 32'h0;
          req_ready        <= 1'b1;
          if (accept) begin
            req_ready  <= 1'b0;
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_lane   <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && (req_funct3 == 3'b010)) begin
              state            <= WRITE;
              mem_write_enable <= 1'b1;
              mem_addr         <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_write_data   <= req_wdata;
            end else begin
              state           <= READ;
              mem_read_enable <= 1'b1;
              mem_addr        <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        READ: begin
          mem_read_enable <= 1'b0;
          if (lat_we) begin
            state            <= WRITE;
            mem_write_enable <= 1'b1;
            mem_write_data   <= merged_word;
          end else begin
            state     <= RESP;
            mem_addr  <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            rsp_err   <= 1'b0;
          end
        end
        WRITE: begin
          state            <= RESP;
          mem_write_enable <= 1'b0;
          mem_write_data   <= 32'h0;
          mem_addr         <= '0;
          rsp_valid        <= 1'b1;
          rsp_rdata        <= 32'h0;
          rsp_err          <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a behavioural word memory.
// Expected responses are queued when a request is issued and popped when
// rsp_valid arrives. Misalignment expectations follow MISALIGN_TRAP_EN.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_compared = 0;
  int          n_failed = 0;
  int          wr_cycles = 0;
  int          rd_cycles = 0;
  int          overlap = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Word memory: combinational read, write on the clock edge
  assign mem_read_data = mem_read_enable ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_addr[9:2]] <= mem_write_data;
  end

  // Observe memory-side activity between clock edges
  always @(negedge clk) begin
    if (mem_write_enable) begin
      wr_cycles    = wr_cycles + 1;
      last_wr_addr = mem_addr;
      last_wr_data = mem_write_data;
    end
    if (mem_read_enable) rd_cycles = rd_cycles + 1;
    if (mem_read_enable && mem_write_enable) overlap = overlap + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its response and compare against the queued expectation
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int exp_rd, input int exp_wr);
    int   wr0;
    int   rd0;
    int   lat;
    exp_t e;
    sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
    @(negedge clk);
    checkOutput({tag, ".ready"}, 32'(req_ready), 32'd1);
    wr0        = wr_cycles;
    rd0        = rd_cycles;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    checkOutput({tag, ".lat"}, 32'(lat), 32'(e.lat));
    checkOutput({tag, ".rdata"}, rsp_rdata, e.rdata);
    checkOutput({tag, ".err"}, 32'(rsp_err), 32'(e.err));
    checkOutput({tag, ".rd_cycles"}, 32'(rd_cycles - rd0), 32'(exp_rd));
    checkOutput({tag, ".wr_cycles"}, 32'(wr_cycles - wr0), 32'(exp_wr));
    @(negedge clk);
    checkOutput({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst.ready", 32'(req_ready), 32'd0);
    checkOutput("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst.we", 32'(mem_write_enable), 32'd0);
    checkOutput("rst.re", 32'(mem_read_enable), 32'd0);
    checkOutput("rst.addr", mem_addr, 32'h0);
    rst_n = 1'b1;

    // Word store then word load
    applyStimulus("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
    checkOutput("sw10.waddr", last_wr_addr, 32'h10);
    checkOutput("sw10.wdata", last_wr_data, 32'hDEADBEEF);
    applyStimulus("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

    // Sub-word stores via read-modify-write
    applyStimulus("sw20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 0, 1);
    applyStimulus("sb22", 1'b1, 3'b000, 32'h22, 32'h123456AA, 32'h0, 1'b0, 3, 1, 1);
    checkOutput("sb22.waddr", last_wr_addr, 32'h20);
    checkOutput("sb22.wdata", last_wr_data, 32'h11AA3344);
    applyStimulus("sh22", 1'b1, 3'b001, 32'h22, 32'h5555BEEF, 32'h0, 1'b0, 3, 1, 1);
    checkOutput("sh22.wdata", last_wr_data, 32'hBEEF3344);
    applyStimulus("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF3344, 1'b0, 2, 1, 0);

    // Signed and unsigned sub-word loads
    applyStimulus("sw30", 1'b1, 3'b010, 32'h30, 32'h8000F0FF, 32'h0, 1'b0, 2, 0, 1);
    applyStimulus("lb30", 1'b0, 3'b000, 32'h30, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 1, 0);
    applyStimulus("lbu30", 1'b0, 3'b100, 32'h30, 32'h0, 32'h000000FF, 1'b0, 2, 1, 0);
    applyStimulus("lh32", 1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF8000, 1'b0, 2, 1, 0);
    applyStimulus("lhu32", 1'b0, 3'b101, 32'h32, 32'h0, 32'h00008000, 1'b0, 2, 1, 0);
    applyStimulus("lb31", 1'b0, 3'b000, 32'h31, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 1, 0);
    applyStimulus("lbu33", 1'b0, 3'b100, 32'h33, 32'h0, 32'h00000080, 1'b0, 2, 1, 0);
    applyStimulus("lhu30", 1'b0, 3'b101, 32'h30, 32'h0, 32'h0000F0FF, 1'b0, 2, 1, 0);

    // Errors and the top-of-memory boundary
    applyStimulus("lw400", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("ld110", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("st011", 1'b1, 3'b011, 32'h10, 32'h1, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("st100", 1'b1, 3'b100, 32'h10, 32'h1, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("sw3fc", 1'b1, 3'b010, 32'h3FC, 32'h0, 32'h0, 1'b0, 2, 0, 1);
    applyStimulus("sb3ff", 1'b1, 3'b000, 32'h3FF, 32'h77, 32'h0, 1'b0, 3, 1, 1);
    applyStimulus("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h77000000, 1'b0, 2, 1, 0);
    applyStimulus("lw400b", 1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    applyStimulus("lw13", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("lh33", 1'b0, 3'b001, 32'h33, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("sw21", 1'b1, 3'b010, 32'h21, 32'h0BADF00D, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("lw20b", 1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF3344, 1'b0, 2, 1, 0);
`else
    applyStimulus("lw13", 1'b0, 3'b010, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);
    applyStimulus("lh33", 1'b0, 3'b001, 32'h33, 32'h0, 32'hFFFF8000, 1'b0, 2, 1, 0);
    applyStimulus("sw21", 1'b1, 3'b010, 32'h21, 32'h0BADF00D, 32'h0, 1'b0, 2, 0, 1);
    checkOutput("sw21.waddr", last_wr_addr, 32'h20);
    applyStimulus("lw20b", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 2, 1, 0);
`endif

    // Reset arriving in the WRITE state of a byte store
    applyStimulus("sw40", 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2, 0, 1);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h41;
    req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstw.read", 32'(mem_read_enable), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rstw.write", 32'(mem_write_enable), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstw.we_drop", 32'(mem_write_enable), 32'd0);
    checkOutput("rstw.ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstw.mem", mem[16], 32'hCAFEF00D);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstw.ready_after", 32'(req_ready), 32'd1);
    checkOutput("rstw.no_rsp", 32'(rsp_valid), 32'd0);
    applyStimulus("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0);

    checkOutput("overlap", 32'(overlap), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
